ram_input_seq: RTL
==================

// Module: ram_input_seq
// PURPOSE
//  Sequencer owning the single port of the input-vector RAM (ram_input_unit, registered read addr, 1-cycle read latency).
//  LOAD: writes a valid/ready input stream into addresses 0..DEPTH-1. SCAN: reads 0..DEPTH-1 back out as a valid/ready
//  stream to the downstream MAC/consumer, absorbing RAM read latency under backpressure with a 2-entry skid buffer.
// PARAMETERS
//  DATA_WIDTH  1    width of one RAM entry / stream beat
//  ADDR_WIDTH  10   RAM address width
//  DEPTH       784  entries loaded/scanned per pass; 1 <= DEPTH <= 2**ADDR_WIDTH
// PORTS
//  clk        in   1           single clock, all state on posedge
//  rst_n      in   1           asynchronous active-low reset
//  load       in   1           pulse: begin LOAD pass (sampled in IDLE only)
//  start      in   1           pulse: begin SCAN pass (sampled in IDLE only)
//  in_valid   in   1           load stream valid
//  in_ready   out  1           load stream ready (1 only in LOAD)
//  in_data    in   DATA_WIDTH  load stream data
//  out_valid  out  1           scan stream valid
//  out_ready  in   1           scan stream ready (consumer backpressure)
//  out_data   out  DATA_WIDTH  scan stream data, registered
//  out_last   out  1           qualifies beat for address DEPTH-1
//  ram_addr   out  ADDR_WIDTH  to RAM addr
//  ram_data   out  DATA_WIDTH  to RAM data (= in_data)
//  ram_we     out  1           to RAM we (= in_valid & in_ready)
//  ram_q      in   DATA_WIDTH  from RAM q, valid the cycle after ram_addr is presented
//  busy       out  1           state != IDLE
//  done       out  1           1-cycle pulse on completion of LOAD or SCAN pass
// BEHAVIOUR
//  Reset: state IDLE; counters 0; in_ready, out_valid, out_last, ram_we, busy, done = 0; ram_addr = 0; out_data = 0.
//  States: IDLE -> LOAD (load=1) | SCAN (start=1, load=0). load and start together in IDLE: load wins, start dropped.
//  LOAD: in_ready=1; each in_valid&in_ready writes in_data at wr_ptr, wr_ptr++. Write of DEPTH-1 -> done pulse next cycle, IDLE.
//  SCAN: rd_ptr issues read when rd_ptr<DEPTH and (buf_cnt + inflight) < 2; inflight is 1 the cycle after an issue.
//   ram_q captured into skid buffer the cycle after issue. out_valid = buf_cnt!=0; pop on out_valid&out_ready.
//   Latency: start sampled at edge 0 -> ram_addr=0 in cycle 1 -> out_valid=1 in cycle 3. out_ready held 1: 1 beat/cycle.
//   Backpressure: no beat lost or duplicated; order strictly address 0..DEPTH-1; out_data/out_last stable while stalled.
//   Pop of beat with out_last -> done pulse next cycle, IDLE. Pointers width ADDR_WIDTH+1 so DEPTH=2**ADDR_WIDTH ends cleanly.
//  load/start outside IDLE ignored; in_valid outside LOAD ignored (no write, in_ready=0).
//  Reset mid-pass: immediate return to IDLE, skid buffer flushed; RAM contents undefined for partial LOAD, never rewritten.
//  ram_addr mux: wr_ptr in LOAD, rd_ptr in SCAN, held otherwise; ram_we never asserted outside LOAD.
// CONFIGURATION
//  RAM_SEQ_STATS_EN defined: adds output stall_cnt [15:0], cleared on start, +1 each SCAN cycle with out_valid & !out_ready,
//   saturates at 16'hFFFF, reset 0. Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package ram_input_pkg: typedef enum logic[1:0] {IDLE, LOAD, SCAN} seq_state_t; default DEPTH/ADDR_WIDTH constants.
//  Sub-module ram_input_skid: 2-entry buffer (push, pop, data, last, cnt); top holds FSM, pointers, RAM port mux.
// TESTING
//  Load 784 beats, in_valid=1 continuous -> 784 ram_we pulses addr 0..783, done 1 cycle after last write, in_ready=0 after.
//  Scan, out_ready=1 -> out_valid first in cycle 3 after start, 784 consecutive beats matching loaded data, out_last on 784th.
//  Scan, out_ready toggled 1-0-0-1 random -> exact in-order 784 beats, no drop/dup, data stable while stalled.
//  load=start=1 in IDLE -> LOAD entered; start pulse during LOAD and in_valid during SCAN -> no effect.
//  rst_n low at beat 300 of SCAN -> all outputs reset values async; next start rescans from address 0.
//  DEPTH=1024, ADDR_WIDTH=10 -> last beat at addr 1023, no wrap to 0; with RAM_SEQ_STATS_EN stall_cnt = stalled cycles.

Source files
------------

// File: rtl/ram_input_pkg.sv
// Shared types and default sizing for the input-vector RAM sequencer.
package ram_input_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } seq_state_t;

  localparam int unsigned DefaultDataWidth = 1;
  localparam int unsigned DefaultAddrWidth = 10;
  localparam int unsigned DefaultDepth     = 784;

endpackage

// File: rtl/ram_input_skid.sv
// Two-entry in-order buffer that absorbs the RAM read latency while the consumer stalls.
module ram_input_skid #(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [1:0]            cnt_q, cnt_d, cnt_mid;
  logic                  pop_ok, push_ok;

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    pop_ok  = pop_i && (cnt_q != 2'd0);
    push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
    cnt_mid = cnt_q - {1'b0, pop_ok};
    if (pop_ok) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    // New beat lands in the first free slot after the pop has shifted the queue.
    if (push_ok) begin
      if (cnt_mid == 2'd0) begin
        data0_d = push_data_i;
        last0_d = push_last_i;
      end else begin
        data1_d = push_data_i;
        last1_d = push_last_i;
      end
    end
    cnt_d = cnt_mid + {1'b0, push_ok};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o = data0_q;
  assign last_o = last0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ram_input_seq.sv
// Input-vector RAM sequencer: LOAD writes a stream into the RAM, SCAN streams it back out.
// Defining RAM_SEQ_STATS_EN adds the saturating stall_cnt_o backpressure counter.
module ram_input_seq
  import ram_input_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef RAM_SEQ_STATS_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  // One extra pointer bit so DEPTH == 2**ADDR_WIDTH terminates without wrapping.
  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);
  localparam logic [PtrW-1:0] LastP  = PtrW'(DEPTH - 1);

  seq_state_t            state_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                  inflight_q, infl_last_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;

  logic                  wr_fire, pop, issue, skid_last;
  logic [1:0]            buf_cnt;
  logic [2:0]            occ;

  assign in_ready_o  = (state_q == LOAD);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign ram_we_o    = in_valid_i & in_ready_o;
  assign ram_data_o  = in_data_i;
  assign wr_fire     = ram_we_o;
  assign out_valid_o = (buf_cnt != 2'd0);
  assign out_last_o  = out_valid_o & skid_last;
  assign pop         = out_valid_o & out_ready_i;

  // Occupancy counts a same-cycle pop so a steady out_ready sustains one beat per cycle.
  assign occ   = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == SCAN) && (rd_ptr_q < DepthP) && (occ < 3'd2);

  always_comb begin
    ram_addr_o = addr_hold_q;
    if (state_q == LOAD) begin
      ram_addr_o = wr_ptr_q[ADDR_WIDTH-1:0];
    end else if ((state_q == SCAN) && (rd_ptr_q < DepthP)) begin
      ram_addr_o = rd_ptr_q[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_hold_q <= '0;
    end else begin
      addr_hold_q <= ram_addr_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      inflight_q  <= issue;
      infl_last_q <= issue && (rd_ptr_q == LastP);
      unique case (state_q)
        IDLE: begin
          if (load_i) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
          end else if (start_i) begin
            state_q  <= SCAN;
            rd_ptr_q <= '0;
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (wr_ptr_q == LastP) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (issue) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
          end
          if (pop && out_last_o) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ram_input_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (ram_q_i),
    .push_last_i (infl_last_q),
    .pop_i       (pop),
    .data_o      (out_data_o),
    .last_o      (skid_last),
    .cnt_o       (buf_cnt)
  );

`ifdef RAM_SEQ_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == IDLE) && start_i && !load_i) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == SCAN) && out_valid_o && !out_ready_i &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
